// File: rtl/pipeline_pkg.sv
// Shared constants, instruction field positions and FSM encoding for the
// ID -> EXM -> WB pipeline control slice.
package pipeline_pkg;

  // Bubble encoding: addi x0,x0,0
  localparam logic [31:0] NOP_INST = 32'h00000013;

  // Instruction field positions
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 7;
  localparam int RS1_MSB = 19;
  localparam int RS1_LSB = 15;
  localparam int RS2_MSB = 24;
  localparam int RS2_LSB = 20;
  localparam int OPC_MSB = 6;
  localparam int OPC_LSB = 0;

  // Flush sequencer states
  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  // Destination register index of an instruction
  function automatic logic [4:0] rd_of(input logic [31:0] inst);
    return inst[RD_MSB:RD_LSB];
  endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// One pipeline register slice: instruction, PC, valid and write enables.
// hold freezes the slice; bubble replaces the payload with a NOP while the
// PC is still captured so a debugger can see where the bubble came from.
module pipe_stage_reg #(
  parameter int          XLEN        = 32,
  parameter logic [31:0] BUBBLE_INST = 32'h00000013
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            hold,
  input  logic            bubble,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  input  logic            in_valid,
  input  logic            in_regwen,
  input  logic [3:0]      in_memwen,
  output logic [31:0]     out_inst,
  output logic [XLEN-1:0] out_pc,
  output logic            out_valid,
  output logic            out_regwen,
  output logic [3:0]      out_memwen
);

  logic [31:0]     inst_q,   inst_d;
  logic [XLEN-1:0] pc_q,     pc_d;
  logic            valid_q,  valid_d;
  logic            regwen_q, regwen_d;
  logic [3:0]      memwen_q, memwen_d;

  // Next slice contents: hold, capture a bubble, or capture the input
  always_comb begin
    inst_d   = inst_q;
    pc_d     = pc_q;
    valid_d  = valid_q;
    regwen_d = regwen_q;
    memwen_d = memwen_q;
    if (!hold) begin
      pc_d = in_pc;
      if (bubble) begin
        inst_d   = BUBBLE_INST;
        valid_d  = 1'b0;
        regwen_d = 1'b0;
        memwen_d = 4'h0;
      end else begin
        inst_d   = in_inst;
        valid_d  = in_valid;
        regwen_d = in_regwen;
        memwen_d = in_memwen;
      end
    end
  end

  // Slice registers with synchronous active-low reset to a bubble at PC 0
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inst_q   <= BUBBLE_INST;
      pc_q     <= '0;
      valid_q  <= 1'b0;
      regwen_q <= 1'b0;
      memwen_q <= 4'h0;
    end else begin
      inst_q   <= inst_d;
      pc_q     <= pc_d;
      valid_q  <= valid_d;
      regwen_q <= regwen_d;
      memwen_q <= memwen_d;
    end
  end

  assign out_inst   = inst_q;
  assign out_pc     = pc_q;
  assign out_valid  = valid_q;
  assign out_regwen = regwen_q;
  assign out_memwen = memwen_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline registers and control for the 3-stage core (ID -> EXM -> WB).
// Inserts bubbles on invalid ID, redirect and the following flush window,
// holds everything on stall, and counts retired instructions.
module pipeline_ctrl #(
  parameter int          XLEN         = 32,
  parameter int          FLUSH_CYCLES = 1,
  parameter logic [31:0] NOP_INST     = 32'h00000013
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [31:0]     id_inst,
  input  logic [XLEN-1:0] id_pc,
  input  logic            id_valid,
  input  logic            id_regwen,
  input  logic [3:0]      id_memwen,
  input  logic            stall,
  input  logic            redirect,
  output logic [31:0]     EXMinst,
  output logic [XLEN-1:0] EXMpc,
  output logic            exm_valid,
  output logic            IDEXMRegWen,
  output logic [3:0]      IDEXMMEMWen,
  output logic [31:0]     WBinst,
  output logic [XLEN-1:0] WBpc,
  output logic            wb_valid,
  output logic            EXMWBRegWen,
  output logic            id_ready,
  output logic            flushing,
  output logic [63:0]     instret
);

  import pipeline_pkg::*;

  localparam int CNT_W = 2;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [63:0]      instret_q, instret_d;
  logic             redirect_acc;
  logic             id_bubble;
  logic             id_regwen_masked;

  // x0 writes are never visible to forwarding
  assign id_regwen_masked = id_regwen & (rd_of(id_inst) != 5'd0);

  // Flush sequencer: accept a redirect in RUN, then squash the remaining
  // FLUSH_CYCLES-1 ID instructions; stall freezes the sequence
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    redirect_acc = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (redirect && exm_valid && !stall) begin
          redirect_acc = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_d = ST_FLUSH;
            cnt_d   = CNT_W'(FLUSH_CYCLES - 1);
          end
        end
      end
      ST_FLUSH: begin
        if (!stall) begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            state_d = ST_RUN;
          end
        end
      end
      default: begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
    endcase
  end

  // FSM state and flush counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign id_bubble = !id_valid || (state_q == ST_FLUSH) || redirect_acc;

  // Retire counter: one per non-stalled edge with a real instruction in WB
  always_comb begin
    instret_d = instret_q;
    if (!stall && wb_valid) begin
      instret_d = instret_q + 64'd1;
    end
  end

  // Retire counter register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      instret_q <= '0;
    end else begin
      instret_q <= instret_d;
    end
  end

  pipe_stage_reg #(
    .XLEN        (XLEN),
    .BUBBLE_INST (NOP_INST)
  ) u_id_exm (
    .clk        (clk),
    .rst_n      (rst_n),
    .hold       (stall),
    .bubble     (id_bubble),
    .in_inst    (id_inst),
    .in_pc      (id_pc),
    .in_valid   (id_valid),
    .in_regwen  (id_regwen_masked),
    .in_memwen  (id_memwen),
    .out_inst   (EXMinst),
    .out_pc     (EXMpc),
    .out_valid  (exm_valid),
    .out_regwen (IDEXMRegWen),
    .out_memwen (IDEXMMEMWen)
  );

  // The EXM/WB store enables are not consumed downstream of WB
  logic [3:0] wb_memwen_unused;

  pipe_stage_reg #(
    .XLEN        (XLEN),
    .BUBBLE_INST (NOP_INST)
  ) u_exm_wb (
    .clk        (clk),
    .rst_n      (rst_n),
    .hold       (stall),
    .bubble     (1'b0),
    .in_inst    (EXMinst),
    .in_pc      (EXMpc),
    .in_valid   (exm_valid),
    .in_regwen  (IDEXMRegWen),
    .in_memwen  (IDEXMMEMWen),
    .out_inst   (WBinst),
    .out_pc     (WBpc),
    .out_valid  (wb_valid),
    .out_regwen (EXMWBRegWen),
    .out_memwen (wb_memwen_unused)
  );

  assign id_ready = ~stall;
  assign flushing = (state_q == ST_FLUSH);
  assign instret  = instret_q;

endmodule
